// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: fetch-address generator with held AR channel, tag FIFO and jump flush.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module ifu_fetch_ctrl #(
  parameter int              ADDR_W          = 32,
  parameter int              FETCH_BYTES     = 4,
  parameter int              MAX_OUTSTANDING = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR    = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              stall_pc_i,
  output logic              ar_valid_o,
  output logic [ADDR_W-1:0] ar_addr_o,
  input  logic              ar_ready_i,
  input  logic              r_valid_i,
  output logic              resp_valid_o,
  output logic [ADDR_W-1:0] resp_pc_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_misaligned_o
);

  localparam int                PTR_W      = $clog2(MAX_OUTSTANDING);
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(FETCH_BYTES - 1));
  localparam logic [ADDR_W-1:0] FETCH_INC  = ADDR_W'(FETCH_BYTES);
  localparam logic [CNT_W-1:0]  FULL       = CNT_W'(MAX_OUTSTANDING);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redir_addr;
  logic              ar_hold;
  logic              redir_pend;
  logic              mis;

  logic [ADDR_W-1:0]          tag_pc [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] tag_kill;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;

  logic              can_issue;
  logic              handshake;
  logic              pop;
  logic              push_kill;
  logic              defer_redirect;
  logic              load_target;
  logic [ADDR_W-1:0] target;

  always_comb begin
    can_issue    = !stall_pc_i && !mis && !redir_pend && (count < FULL);
    // Valid is gated by reset so the bus sees no request while the block is held in reset.
    ar_valid_o   = rst_n && (ar_hold || can_issue);
    ar_addr_o    = pc & ALIGN_MASK;
    handshake    = ar_valid_o && ar_ready_i;
    pop          = r_valid_i && (count != '0);
    resp_valid_o = pop && !tag_kill[rd_ptr] && !jump_flag_i;
    resp_pc_o    = tag_pc[rd_ptr];
    pc_o         = pc;
    pc_misaligned_o = mis;
    push_kill    = jump_flag_i || redir_pend;
    // A request already on the bus and not accepted must keep its address, so the target waits.
    defer_redirect = jump_flag_i && ar_valid_o && !ar_ready_i;
    load_target    = (jump_flag_i && !defer_redirect) || (handshake && redir_pend && !jump_flag_i);
    target         = jump_flag_i ? jump_addr_i : redir_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_ADDR;
      redir_addr <= '0;
      ar_hold    <= 1'b0;
      redir_pend <= 1'b0;
      mis        <= 1'b0;
    end else begin
      ar_hold <= ar_valid_o && !ar_ready_i;
      if (defer_redirect) begin
        redir_pend <= 1'b1;
        redir_addr <= jump_addr_i;
      end else if (load_target) begin
        pc         <= target;
        mis        <= |target[1:0];
        redir_pend <= 1'b0;
      end else if (handshake) begin
        pc <= ar_addr_o + FETCH_INC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tag_kill <= '0;
    end else begin
      if (jump_flag_i) tag_kill <= '1;
      if (handshake) begin
        tag_kill[wr_ptr] <= push_kill;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(handshake) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (handshake) tag_pc[wr_ptr] <= pc;
  end

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomised scoreboard bench for ifu_fetch_ctrl against a queue-based fetch model.
`timescale 1ns/1ps
`default_nettype none

module tb_ifu_fetch_ctrl;

  localparam int          AW     = 32;
  localparam int          FB     = 8;
  localparam int          MAXO   = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] AMASK  = ~(32'(FB - 1));

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        stall_pc_i = 1'b0;
  logic        ar_ready_i = 1'b0;
  logic        r_valid_i = 1'b0;
  logic        ar_valid_o;
  logic [31:0] ar_addr_o;
  logic        resp_valid_o;
  logic [31:0] resp_pc_o;
  logic [31:0] pc_o;
  logic        pc_misaligned_o;

  ifu_fetch_ctrl #(
    .ADDR_W(AW), .FETCH_BYTES(FB), .MAX_OUTSTANDING(MAXO), .RESET_ADDR(RST_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .stall_pc_i(stall_pc_i),
    .ar_valid_o(ar_valid_o), .ar_addr_o(ar_addr_o), .ar_ready_i(ar_ready_i),
    .r_valid_i(r_valid_i), .resp_valid_o(resp_valid_o), .resp_pc_o(resp_pc_o),
    .pc_o(pc_o), .pc_misaligned_o(pc_misaligned_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int live_resps = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the fetch stream as a PC, a pending-redirect slot and a queue of
  // outstanding fetches, each remembering its start PC and whether a jump has orphaned it.
  typedef struct { logic [31:0] pc; bit dead; } exp_t;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] m_pc;
  logic [31:0] m_pend_addr;
  bit          m_pend, m_held, m_mis;
  int          m_inflight;
  bit          mv, mhs, mpop, chk_v, mon_live;

  function automatic bit m_valid();
    return m_held || (!stall_pc_i && !m_mis && !m_pend && m_inflight < MAXO);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RST_PC; m_pend = 0; m_pend_addr = '0; m_held = 0; m_mis = 0; m_inflight = 0;
      exp_q.delete();
    end else begin
      mv   = m_valid();
      mhs  = mv && ar_ready_i;
      mpop = r_valid_i && (m_inflight > 0);
      if (jump_flag_i) foreach (exp_q[i]) exp_q[i].dead = 1;
      if (mhs) exp_q.push_back('{pc: m_pc, dead: (jump_flag_i || m_pend)});
      if (jump_flag_i) begin
        if (mv && !ar_ready_i) begin
          m_pend = 1; m_pend_addr = jump_addr_i;
        end else begin
          m_pc = jump_addr_i; m_mis = (jump_addr_i[1:0] != 2'b00); m_pend = 0;
        end
      end else if (mhs) begin
        if (m_pend) begin
          m_pc = m_pend_addr; m_mis = (m_pend_addr[1:0] != 2'b00); m_pend = 0;
        end else begin
          m_pc = (m_pc & AMASK) + 32'(FB);
        end
      end
      m_held     = mv && !ar_ready_i;
      m_inflight = m_inflight + int'(mhs) - int'(mpop);
    end
  end

  // Request-side checker.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ar_valid", 32'(ar_valid_o), 32'd0);
      check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
      check("rst_misaligned", 32'(pc_misaligned_o), 32'd0);
      check("rst_pc", pc_o, RST_PC);
    end else begin
      chk_v = m_valid();
      check("ar_valid", 32'(ar_valid_o), 32'(chk_v));
      if (chk_v) check("ar_addr", ar_addr_o, m_pc & AMASK);
      check("pc", pc_o, m_pc);
      check("misaligned", 32'(pc_misaligned_o), 32'(m_mis));
    end
  end

  // Response monitor: pops the scoreboard whenever a beat arrives.
  always @(negedge clk) begin
    if (rst_n) begin
      if (r_valid_i && exp_q.size() > 0) begin
        mon_e    = exp_q.pop_front();
        mon_live = !mon_e.dead && !jump_flag_i;
        check("resp_valid", 32'(resp_valid_o), 32'(mon_live));
        if (mon_live) begin
          check("resp_pc", resp_pc_o, mon_e.pc);
          live_resps++;
        end
      end else begin
        check("resp_idle", 32'(resp_valid_o), 32'd0);
      end
    end
  end

  task automatic step(input bit jf, input logic [31:0] ja, input bit st, input bit rd,
                      input bit rv, input bit chk = 0, input logic [31:0] ea = '0);
    jump_flag_i = jf; jump_addr_i = ja; stall_pc_i = st; ar_ready_i = rd; r_valid_i = rv;
    @(negedge clk);
    if (chk) begin
      check("anchor_valid", 32'(ar_valid_o), 32'd1);
      check("anchor_addr", ar_addr_o, ea);
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ja;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming
    step(0, 0, 0, 1, 0, 1, 32'h8000_0000);
    step(0, 0, 0, 1, 0, 1, 32'h8000_0008);
    step(0, 0, 0, 1, 0, 1, 32'h8000_0010);
    repeat (3) step(0, 0, 1, 0, 1);
    // Backpressure then fill to capacity, one pop, drain (last beat is a stray)
    repeat (3) step(0, 0, 0, 0, 0, 1, 32'h8000_0018);
    repeat (6) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0, 1, 32'h8000_0038);
    repeat (5) step(0, 0, 1, 0, 1);
    // Flush
    repeat (3) step(0, 0, 0, 1, 0);
    step(1, 32'h8000_0100, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1, 32'h8000_0100);
    repeat (3) step(0, 0, 1, 0, 1);
    // Held redirect
    step(0, 0, 0, 0, 0, 1, 32'h8000_0108);
    step(1, 32'h8000_0200, 0, 0, 0, 1, 32'h8000_0108);
    step(0, 0, 0, 0, 0, 1, 32'h8000_0108);
    step(0, 0, 0, 1, 0, 1, 32'h8000_0108);
    step(0, 0, 0, 1, 1, 1, 32'h8000_0200);
    repeat (2) step(0, 0, 1, 0, 1);
    // Misaligned, then recovery
    step(1, 32'h8000_0102, 1, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    step(1, 32'h8000_0300, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1, 32'h8000_0300);
    step(0, 0, 1, 0, 1);
    // Unaligned start
    step(1, 32'h8000_0104, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1, 32'h8000_0100);
    step(0, 0, 0, 1, 0, 1, 32'h8000_0108);
    repeat (2) step(0, 0, 1, 0, 1);

    // Random traffic with a mid-run reset and occasional address wrap
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_n = 1'b0;
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        rst_n = 1'b1;
      end
      ja = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
      if ($urandom % 8 == 0) ja[1:0] = 2'($urandom);
      if ($urandom % 50 == 0) ja = 32'hFFFF_FFF8;
      step(($urandom % 16) == 0, ja, ($urandom % 4) == 0, ($urandom % 3) != 0,
           ($urandom % 2) == 0);
    end

    step(0, 0, 1, 0, 0);
    check("live_responses_seen", 32'(live_resps > 20), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
